// File: rtl/embcpu4k_oci_dct_pkg.sv
// rtl/embcpu4k_oci_dct_pkg.sv - shared widths, state encoding and helpers for the OCI DCT scheduler
package embcpu4k_oci_dct_pkg;

  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;
  localparam int DCT_WORD_W = DCT_CNT_W + DCT_BUF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } dct_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/embcpu4k_oci_dct_skid.sv
// rtl/embcpu4k_oci_dct_skid.sv - 2-entry FIFO absorbing trace words while the RAM port is busy
module embcpu4k_oci_dct_skid
  import embcpu4k_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DCT_WORD_W-1:0] wdata_i,
  output logic [DCT_WORD_W-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DCT_WORD_W-1:0] mem_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 2'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= !wr_ptr_q;
      if (do_pop)  rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/embcpu4k_nios2_oci_dct_sched.sv
// rtl/embcpu4k_nios2_oci_dct_sched.sv - DCT capture FSM and trace RAM arbiter; OCI_DCT_DROP_CNT_EN adds dct_drop_cnt
module embcpu4k_nios2_oci_dct_sched
  import embcpu4k_oci_dct_pkg::*;
#(
  parameter int AW             = 7,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_en,
  input  logic                  dct_valid,
  output logic                  dct_ready,
  input  logic [DCT_BUF_W-1:0]  dct_buffer,
  input  logic [DCT_CNT_W-1:0]  dct_count,
  input  logic                  test_ending,
  output logic                  test_has_ended,
  output logic [AW-1:0]         tm_addr,
  output logic                  tm_wr,
  output logic [DCT_WORD_W-1:0] tm_wdata,
  output logic                  tm_rd,
  input  logic [DCT_WORD_W-1:0] tm_rdata,
  input  logic                  host_rd_req,
  input  logic [AW-1:0]         host_rd_addr,
  output logic                  host_rd_gnt,
  output logic                  host_rd_valid,
  output logic [DCT_WORD_W-1:0] host_rd_data,
`ifdef OCI_DCT_DROP_CNT_EN
  output logic [7:0]            dct_drop_cnt,
`endif
  output logic [AW-1:0]         wr_ptr,
  output logic                  wrapped,
  output logic                  dct_overflow
);

  localparam int BW = $clog2(HOST_BURST_MAX + 1);

  dct_state_e            state_q, state_d;
  logic [AW-1:0]         wr_ptr_q;
  logic                  wrapped_q, ovf_q, rd_valid_q;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  fifo_full, fifo_empty, push, drop;
  logic                  wr_pri, host_go, wr_go;
  logic [DCT_WORD_W-1:0] fifo_head;

  embcpu4k_oci_dct_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (wr_go),
    .wdata_i ({dct_count, dct_buffer}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (test_ending) state_d = ENDED;
             else if (trace_en) state_d = RUN;
      RUN:   if (test_ending) state_d = DRAIN;
             else if (!trace_en && fifo_empty) state_d = IDLE;
      DRAIN: if (fifo_empty) state_d = ENDED;
      default: state_d = state_q;
    endcase
  end

  // An empty FIFO in DRAIN means the last write has already gone out.
  always_comb begin
    dct_ready      = 1'b0;
    test_has_ended = 1'b0;
    case (state_q)
      IDLE:    dct_ready = 1'b1;
      RUN:     dct_ready = !fifo_full;
      DRAIN:   test_has_ended = fifo_empty;
      default: test_has_ended = 1'b1;
    endcase
  end

  assign push = (state_q == RUN) && trace_en && dct_valid && dct_ready && (dct_count != '0);
  assign drop = (state_q == RUN) && dct_valid && !dct_ready;

  always_comb begin
    wr_pri  = !fifo_empty && (fifo_full || (state_q == DRAIN));
    host_go = !wr_pri && host_rd_req && (burst_q < BW'(HOST_BURST_MAX));
    wr_go   = wr_pri || (!host_go && !fifo_empty);
    burst_d = burst_q;
    if (wr_go || fifo_empty) burst_d = '0;
    else if (host_go)        burst_d = burst_q + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      burst_q    <= '0;
    end else begin
      rd_valid_q <= host_go;
      burst_q    <= burst_d;
      if (drop) ovf_q <= 1'b1;
      if (wr_go) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (wr_ptr_q == {AW{1'b1}}) wrapped_q <= 1'b1;
      end
    end
  end

`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)     drop_cnt_q <= 8'd0;
    else if (drop) drop_cnt_q <= sat_inc8(drop_cnt_q);
  end

  assign dct_drop_cnt = drop_cnt_q;
`endif

  assign tm_wr         = wr_go;
  assign tm_rd         = host_go;
  assign host_rd_gnt   = host_go;
  assign tm_addr       = host_go ? host_rd_addr : (wr_go ? wr_ptr_q : '0);
  assign tm_wdata      = wr_go ? fifo_head : '0;
  assign host_rd_valid = rd_valid_q;
  assign host_rd_data  = rd_valid_q ? tm_rdata : '0;
  assign wr_ptr        = wr_ptr_q;
  assign wrapped       = wrapped_q;
  assign dct_overflow  = ovf_q;

endmodule

// File: tb/tb_embcpu4k_nios2_oci_dct_sched.sv
// tb/tb_embcpu4k_nios2_oci_dct_sched.sv - directed self-checking bench for the OCI DCT scheduler
module tb_embcpu4k_nios2_oci_dct_sched;

  logic        clk = 1'b0;
  logic        reset, trace_en, dct_valid, dct_ready, test_ending, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [6:0]  tm_addr, host_rd_addr, wr_ptr;
  logic        tm_wr, tm_rd, host_rd_req, host_rd_gnt, host_rd_valid, wrapped, dct_overflow;
  logic [33:0] tm_wdata, tm_rdata, host_rd_data;
`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0]  dct_drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [33:0] ram [128];

  always #5 clk = !clk;

  always @(posedge clk) begin
    if (tm_wr) ram[tm_addr] <= tm_wdata;
    if (tm_rd) tm_rdata <= ram[tm_addr];
  end

  embcpu4k_nios2_oci_dct_sched dut (
    .clk            (clk),
    .reset          (reset),
    .trace_en       (trace_en),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .tm_addr        (tm_addr),
    .tm_wr          (tm_wr),
    .tm_wdata       (tm_wdata),
    .tm_rd          (tm_rd),
    .tm_rdata       (tm_rdata),
    .host_rd_req    (host_rd_req),
    .host_rd_addr   (host_rd_addr),
    .host_rd_gnt    (host_rd_gnt),
    .host_rd_valid  (host_rd_valid),
    .host_rd_data   (host_rd_data),
`ifdef OCI_DCT_DROP_CNT_EN
    .dct_drop_cnt   (dct_drop_cnt),
`endif
    .wr_ptr         (wr_ptr),
    .wrapped        (wrapped),
    .dct_overflow   (dct_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] w(input logic [3:0] c, input logic [29:0] b);
    return {c, b};
  endfunction

  initial begin
    reset = 1'b1; trace_en = 1'b0; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; host_rd_req = 1'b0; host_rd_addr = '0;
    step(); step();
    reset = 1'b0; #1;
    chk("rst_ready", dct_ready, 1);
    chk("rst_ended", test_has_ended, 0);
    chk("rst_tm_wr", tm_wr, 0);
    chk("rst_tm_rd", tm_rd, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_ovf", dct_overflow, 0);
    chk("rst_rvalid", host_rd_valid, 0);

    // three words, no host traffic
    trace_en = 1'b1; step();
    dct_valid = 1'b1; dct_count = 4'd5; dct_buffer = 30'h1; #1;
    chk("t1_no_wr_yet", tm_wr, 0);
    step(); dct_buffer = 30'h2; #1;
    chk("t1_wr0", tm_wr, 1); chk("t1_addr0", tm_addr, 0); chk("t1_data0", tm_wdata, w(5, 30'h1));
    step(); dct_buffer = 30'h3; #1;
    chk("t1_addr1", tm_addr, 1); chk("t1_data1", tm_wdata, w(5, 30'h2));
    step(); dct_valid = 1'b0; #1;
    chk("t1_addr2", tm_addr, 2); chk("t1_data2", tm_wdata, w(5, 30'h3));
    step(); #1;
    chk("t1_idle_wr", tm_wr, 0); chk("t1_wr_ptr", wr_ptr, 3);

    // zero-count word is swallowed
    dct_valid = 1'b1; dct_count = 4'd0; dct_buffer = 30'h3ff; #1;
    chk("t2_ready", dct_ready, 1);
    step(); dct_valid = 1'b0; #1;
    chk("t2_no_wr", tm_wr, 0); chk("t2_wr_ptr", wr_ptr, 3); chk("t2_ovf", dct_overflow, 0);

    // host burst of four grants then one capture write
    dct_valid = 1'b1; dct_count = 4'd7; dct_buffer = 30'h55; host_rd_req = 1'b1; host_rd_addr = 7'd0; #1;
    chk("t3_gnt_empty", host_rd_gnt, 1); chk("t3_tm_rd", tm_rd, 1); chk("t3_raddr", tm_addr, 0);
    step(); dct_valid = 1'b0; #1;
    chk("t3_rvalid", host_rd_valid, 1); chk("t3_rdata", host_rd_data, w(5, 30'h1));
    chk("t3_gnt1", host_rd_gnt, 1);
    step(); #1; chk("t3_gnt2", host_rd_gnt, 1);
    step(); #1; chk("t3_gnt3", host_rd_gnt, 1);
    step(); #1; chk("t3_gnt4", host_rd_gnt, 1);
    step(); #1;
    chk("t3_gnt_stop", host_rd_gnt, 0); chk("t3_wr", tm_wr, 1);
    chk("t3_waddr", tm_addr, 3); chk("t3_wdata", tm_wdata, w(7, 30'h55));

    // full FIFO beats the host immediately
    step(); dct_valid = 1'b1; dct_count = 4'd2; dct_buffer = 30'ha; #1;
    chk("t3b_gnt_a", host_rd_gnt, 1);
    step(); dct_buffer = 30'hb; #1;
    chk("t3b_gnt_b", host_rd_gnt, 1); chk("t3b_no_wr", tm_wr, 0);
    step(); dct_valid = 1'b0; #1;
    chk("t3b_full_wr", tm_wr, 1); chk("t3b_full_gnt", host_rd_gnt, 0);
    chk("t3b_full_addr", tm_addr, 4); chk("t3b_full_data", tm_wdata, w(2, 30'ha));
    chk("t3b_full_ready", dct_ready, 0);
    step(); #1; chk("t3b_gnt_after", host_rd_gnt, 1);
    step(); host_rd_req = 1'b0; #1;
    chk("t3b_wr_b", tm_addr, 5); chk("t3b_data_b", tm_wdata, w(2, 30'hb));
    step(); #1; chk("t3b_wr_ptr", wr_ptr, 6);

    // overflow with host and packer both busy
    host_rd_req = 1'b1; dct_valid = 1'b1; dct_count = 4'd4; dct_buffer = 30'h77;
    step(); step(); #1;
    chk("t4_full_ready", dct_ready, 0); chk("t4_full_addr", tm_addr, 6);
    step(); dct_valid = 1'b0; host_rd_req = 1'b0; #1;
    chk("t4_ovf", dct_overflow, 1);
`ifdef OCI_DCT_DROP_CNT_EN
    chk("t4_drop_cnt1", dct_drop_cnt, 1);
`endif
    step(); step(); #1;
    chk("t4_wr_ptr", wr_ptr, 8);

    // reset mid-run, then wrap the buffer
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("t5_rst_ptr", wr_ptr, 0); chk("t5_rst_ovf", dct_overflow, 0);
    step();
    dct_count = 4'd1;
    for (int i = 1; i <= 130; i++) begin
      dct_valid = 1'b1; dct_buffer = 30'(i); #1;
      if (i == 129) begin
        chk("t5_addr127", tm_addr, 127); chk("t5_not_wrapped", wrapped, 0);
      end
      if (i == 130) begin
        chk("t5_wrapped", wrapped, 1); chk("t5_addr0", tm_addr, 0);
        chk("t5_data129", tm_wdata, w(1, 30'd129));
      end
      step();
    end
    dct_valid = 1'b0; #1;
    chk("t5_addr1", tm_addr, 1); chk("t5_data130", tm_wdata, w(1, 30'd130));
    step(); #1;
    chk("t5_wr_ptr", wr_ptr, 2); chk("t5_wrapped_hold", wrapped, 1);

`ifdef OCI_DCT_DROP_CNT_EN
    host_rd_req = 1'b1; dct_valid = 1'b1; dct_count = 4'd3;
    for (int i = 0; i < 700; i++) step();
    host_rd_req = 1'b0; dct_valid = 1'b0; #1;
    chk("t4b_drop_sat", dct_drop_cnt, 255);
    step(); step(); step();
`endif

    // drain with two words queued and host requesting
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("t6_rst_ptr", wr_ptr, 0); chk("t6_rst_wrapped", wrapped, 0);
    step();
    host_rd_req = 1'b1; host_rd_addr = 7'd1; dct_valid = 1'b1; dct_count = 4'd3; dct_buffer = 30'h111;
    step(); dct_buffer = 30'h222; #1;
    chk("t6_fill_gnt", host_rd_gnt, 1);
    step(); dct_valid = 1'b0; test_ending = 1'b1; #1;
    chk("t6_wr1", tm_wr, 1); chk("t6_data1", tm_wdata, w(3, 30'h111)); chk("t6_gnt1", host_rd_gnt, 0);
    step(); test_ending = 1'b0; #1;
    chk("t6_wr2", tm_wr, 1); chk("t6_addr2", tm_addr, 1); chk("t6_data2", tm_wdata, w(3, 30'h222));
    chk("t6_gnt2", host_rd_gnt, 0); chk("t6_ready", dct_ready, 0); chk("t6_not_ended", test_has_ended, 0);
    step(); #1;
    chk("t6_ended", test_has_ended, 1); chk("t6_host_gnt", host_rd_gnt, 1); chk("t6_host_addr", tm_addr, 1);
    step(); reset = 1'b1; #1;
    chk("t6_ended_hold", test_has_ended, 1); chk("t6_rvalid", host_rd_valid, 1);
    chk("t6_rdata", host_rd_data, w(3, 30'h222)); chk("t6_gnt_ended", host_rd_gnt, 1);
    step(); reset = 1'b0; host_rd_req = 1'b0; trace_en = 1'b0; #1;
    chk("t6_rst_rvalid", host_rd_valid, 0); chk("t6_rst_ended", test_has_ended, 0);
    chk("t6_rst_ready", dct_ready, 1);

    // IDLE discards words and jumps straight to ENDED on test_ending
    dct_valid = 1'b1; dct_count = 4'd6; dct_buffer = 30'h9; #1;
    chk("t7_idle_ready", dct_ready, 1);
    step(); dct_valid = 1'b0; #1;
    chk("t7_idle_no_wr", tm_wr, 0);
    test_ending = 1'b1; step(); test_ending = 1'b0; #1;
    chk("t7_idle_ended", test_has_ended, 1); chk("t7_idle_ovf", dct_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
